// File: rtl/snn_run_sequencer.sv
// snn_run_sequencer: FSM sequencing an SNN inference over layers/timesteps via 4-phase handshakes with a watchdog
module snn_run_sequencer #(
  parameter int NUM_TS     = 10,
  parameter int NUM_LAYERS = 2,
  parameter int TS_W       = 4,
  parameter int LY_W       = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [3:0]      err_state_o,
  output logic            flt_req_o,
  input  logic            flt_ack_i,
  output logic [LY_W-1:0] flt_layer_o,
  output logic            ts_req_o,
  input  logic            ts_ack_i,
  output logic [TS_W-1:0] ts_data_o,
  input  logic            ld_req_i,
  output logic            ld_ack_o,
  output logic            run_req_o,
  input  logic            run_ack_i,
  output logic [TS_W-1:0] run_ts_o,
  output logic [LY_W-1:0] run_layer_o,
  input  logic            cmp_req_i,
  output logic            cmp_ack_o
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FLT_UP   = 4'd1;
  localparam logic [3:0] S_FLT_DN   = 4'd2;
  localparam logic [3:0] S_TS_UP    = 4'd3;
  localparam logic [3:0] S_TS_DN    = 4'd4;
  localparam logic [3:0] S_LD_WAIT  = 4'd5;
  localparam logic [3:0] S_LD_REL   = 4'd6;
  localparam logic [3:0] S_RUN_UP   = 4'd7;
  localparam logic [3:0] S_RUN_DN   = 4'd8;
  localparam logic [3:0] S_CMP_WAIT = 4'd9;
  localparam logic [3:0] S_CMP_REL  = 4'd10;
  localparam logic [3:0] S_NEXT     = 4'd11;
  localparam logic [3:0] S_ERR      = 4'd12;

  logic [4:0]      s1_q, s2_q;
  logic [3:0]      state_q, state_d, err_state_q, err_state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [LY_W-1:0] layer_q, layer_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d, done_q, done_d;
  logic            flt_ack_s, ts_ack_s, ld_req_s, run_ack_s, cmp_req_s;
  logic            active, start, wd_exp, adv, ts_last, ly_last;

  assign {cmp_req_s, run_ack_s, ld_req_s, ts_ack_s, flt_ack_s} = s2_q;
  assign active  = state_q != S_IDLE && state_q != S_ERR;
  assign start   = !active && go_i;
  assign wd_exp  = active && wd_q == WD_W'(TIMEOUT);
  assign ts_last = ts_q == TS_W'(NUM_TS - 1);
  assign ly_last = layer_q == LY_W'(NUM_LAYERS - 1);
  // Counters advance when leaving CMP_REL so the new indices are settled a cycle before the next req rises
  assign adv     = state_q == S_CMP_REL && !cmp_req_s && !wd_exp;

  // Next-state decode; a wrapped ts/layer pair of zero in NEXT marks the end of the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = go_i ? S_FLT_UP : S_IDLE;
      S_FLT_UP:   state_d = flt_ack_s ? S_FLT_DN : S_FLT_UP;
      S_FLT_DN:   state_d = flt_ack_s ? S_FLT_DN : S_TS_UP;
      S_TS_UP:    state_d = ts_ack_s ? S_TS_DN : S_TS_UP;
      S_TS_DN:    state_d = ts_ack_s ? S_TS_DN : S_LD_WAIT;
      S_LD_WAIT:  state_d = ld_req_s ? S_LD_REL : S_LD_WAIT;
      S_LD_REL:   state_d = ld_req_s ? S_LD_REL : S_RUN_UP;
      S_RUN_UP:   state_d = run_ack_s ? S_RUN_DN : S_RUN_UP;
      S_RUN_DN:   state_d = run_ack_s ? S_RUN_DN : S_CMP_WAIT;
      S_CMP_WAIT: state_d = cmp_req_s ? S_CMP_REL : S_CMP_WAIT;
      S_CMP_REL:  state_d = cmp_req_s ? S_CMP_REL : S_NEXT;
      S_NEXT:     state_d = ts_q != '0 ? S_TS_UP : layer_q != '0 ? S_FLT_UP : S_IDLE;
      S_ERR:      state_d = go_i ? S_FLT_UP : S_ERR;
      default:    state_d = S_IDLE;
    endcase
    if (wd_exp) state_d = S_ERR;
  end

  // Counter, watchdog and status next values
  always_comb begin
    ts_d        = start ? '0 : adv ? (ts_last ? '0 : ts_q + TS_W'(1)) : ts_q;
    layer_d     = start ? '0 : (adv && ts_last) ? (ly_last ? '0 : layer_q + LY_W'(1)) : layer_q;
    wd_d        = (!active || state_d != state_q) ? '0 : wd_exp ? wd_q : wd_q + WD_W'(1);
    err_d       = wd_exp ? 1'b1 : start ? 1'b0 : err_q;
    err_state_d = wd_exp ? state_q : err_state_q;
    done_d      = state_q == S_NEXT && state_d == S_IDLE;
  end

  // Two-flop synchronizers for the asynchronous handshake inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {cmp_req_i, run_ack_i, ld_req_i, ts_ack_i, flt_ack_i};
      s2_q <= s1_q;
    end

  // FSM state, indices, watchdog and status registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      layer_q     <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      err_state_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      layer_q     <= layer_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      err_state_q <= err_state_d;
      done_q      <= done_d;
    end

  assign busy_o      = active;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_state_o = err_state_q;
  assign flt_req_o   = state_q == S_FLT_UP;
  assign ts_req_o    = state_q == S_TS_UP;
  assign ld_ack_o    = state_q == S_LD_REL;
  assign run_req_o   = state_q == S_RUN_UP;
  assign cmp_ack_o   = state_q == S_CMP_REL;
  assign flt_layer_o = layer_q;
  assign ts_data_o   = ts_q;
  assign run_ts_o    = ts_q;
  assign run_layer_o = layer_q;
endmodule
